apb_rr_master: RTL and testbench

//  Two-requester APB master: round-robin arbitrates two simple memory-request ports and

---
 rtl/apb_rr_master.sv | 159 +++++++++++++++
 tb/tb_apb_rr_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master.sv
// Two-client round-robin APB master driving one APB slave through SETUP/ACCESS.
// Optional ACCESS-phase timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_rr_master #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_i,
  input  logic [1:0]            rnw_i,
  input  logic [2*ADDR_W-1:0]   addr_i,
  input  logic [2*DATA_W-1:0]   wdata_i,
  output logic [1:0]            done_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic [ADDR_W-1:0]     paddr_o,
  output logic                  pwrite_o,
  output logic [DATA_W-1:0]     pwdata_o,
  input  logic [DATA_W-1:0]     prdata_i,
  input  logic                  pready_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                grant, grant_nxt;
  logic                last, last_nxt;
  logic                sel;
  logic [1:0]          eligible;
  logic                psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0]   paddr_nxt;
  logic [DATA_W-1:0]   pwdata_nxt, rdata_nxt;
  logic [1:0]          done_nxt;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                err_nxt;
`endif

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    last_nxt    = last;
    psel_nxt    = psel_o;
    penable_nxt = penable_o;
    paddr_nxt   = paddr_o;
    pwrite_nxt  = pwrite_o;
    pwdata_nxt  = pwdata_o;
    done_nxt    = '0;
    rdata_nxt   = '0;
    sel         = 1'b0;
    // the client completing this cycle is masked so the other gets a turn
    eligible    = req_i & ~done_o;
`ifdef APB_TIMEOUT_EN
    cnt_nxt     = cnt;
    err_nxt     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|eligible) begin
          sel         = (eligible == 2'b11) ? ~last : eligible[1];
          grant_nxt   = sel;
          psel_nxt    = 1'b1;
          paddr_nxt   = sel ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
          pwrite_nxt  = ~rnw_i[sel];
          pwdata_nxt  = rnw_i[sel] ? '0
                      : (sel ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0]);
          state_nxt   = SETUP;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_nxt     = '0;
`endif
      end
      ACCESS: begin
        if (pready_i) begin
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          paddr_nxt   = '0;
          pwrite_nxt  = 1'b0;
          pwdata_nxt  = '0;
          done_nxt    = grant ? 2'b10 : 2'b01;
          rdata_nxt   = pwrite_o ? '0 : prdata_i;
          last_nxt    = grant;
          state_nxt   = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        // this wait cycle is the TIMEOUT-th one without pready: abort
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          paddr_nxt   = '0;
          pwrite_nxt  = 1'b0;
          pwdata_nxt  = '0;
          done_nxt    = grant ? 2'b10 : 2'b01;
          err_nxt     = 1'b1;
          last_nxt    = grant;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt     = cnt + 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 1'b0;
      last      <= 1'b1;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      paddr_o   <= '0;
      pwrite_o  <= 1'b0;
      pwdata_o  <= '0;
      done_o    <= '0;
      rdata_o   <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      last      <= last_nxt;
      psel_o    <= psel_nxt;
      penable_o <= penable_nxt;
      paddr_o   <= paddr_nxt;
      pwrite_o  <= pwrite_nxt;
      pwdata_o  <= pwdata_nxt;
      done_o    <= done_nxt;
      rdata_o   <= rdata_nxt;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      err_o <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      err_o <= err_nxt;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master with a 16x32 APB slave memory and reference memory model.
module tb_apb_rr_master;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          req_i, rnw_i;
  logic [2*ADDR_W-1:0] addr_i;
  logic [2*DATA_W-1:0] wdata_i;
  logic [1:0]          done_o;
  logic [DATA_W-1:0]   rdata_o;
  logic                err_o, psel_o, penable_o, pwrite_o, pready_i;
  logic [ADDR_W-1:0]   paddr_o;
  logic [DATA_W-1:0]   pwdata_o, prdata_i;
  logic [79:0]         outs;

  logic [DATA_W-1:0]   slave_mem [16] = '{default: '0};
  logic [DATA_W-1:0]   ref_mem   [16] = '{default: '0};

  int checks = 0;
  int errors = 0;

  apb_rr_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .rnw_i(rnw_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 clk = ~clk;

  assign outs     = {done_o, rdata_o, err_o, psel_o, penable_o, paddr_o, pwrite_o, pwdata_o};
  assign prdata_i = slave_mem[paddr_o[3:0]];

  always @(posedge clk)
    if (psel_o && penable_o && pready_i && pwrite_o) slave_mem[paddr_o[3:0]] <= pwdata_o;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // One complete transfer by client c; optional wait states, req drop and other-client noise.
  task automatic run_xfer(input int c, input logic rd, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input int waits,
                          input logic drop, input logic noise);
    int o;
    logic [1:0]        exp_done;
    logic [DATA_W-1:0] exp_rdata, exp_pwdata;
    o          = 1 - c;
    exp_done   = (c == 0) ? 2'b01 : 2'b10;
    exp_rdata  = rd ? ref_mem[a[3:0]] : '0;
    exp_pwdata = rd ? '0 : d;
    req_i[c] = 1'b1;
    rnw_i[c] = rd;
    addr_i[c*ADDR_W +: ADDR_W]  = a;
    wdata_i[c*DATA_W +: DATA_W] = d;
    pready_i = (waits == 0);
    @(negedge clk);
    checks++;
    if ({psel_o, penable_o, paddr_o, pwrite_o, pwdata_o} !== {1'b1, 1'b0, a, ~rd, exp_pwdata})
      $display("FAIL setup c%0d: psel=%b pen=%b addr=%h wr=%b wd=%h, want 1 0 %h %b %h",
               c, psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, a, ~rd, exp_pwdata);
    if ({psel_o, penable_o, paddr_o, pwrite_o, pwdata_o} !== {1'b1, 1'b0, a, ~rd, exp_pwdata})
      errors++;
    if (drop) req_i[c] = 1'b0;
    for (int k = 0; k <= waits; k++) begin
      if (noise) begin
        req_i[o] = 1'($urandom);
        rnw_i[o] = 1'($urandom);
        addr_i[o*ADDR_W +: ADDR_W]  = ADDR_W'($urandom);
        wdata_i[o*DATA_W +: DATA_W] = $urandom;
      end
      @(negedge clk);
      checks++;
      if ({psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, done_o} !==
          {2'b11, a, ~rd, exp_pwdata, 2'b00}) begin
        errors++;
        $display("FAIL access c%0d k%0d: psel=%b pen=%b addr=%h wr=%b wd=%h done=%b, want 11 %h %b %h 00",
                 c, k, psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, done_o, a, ~rd, exp_pwdata);
      end
      if (k == waits) pready_i = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (outs !== {exp_done, exp_rdata, 1'b0, 2'b00, {ADDR_W{1'b0}}, 1'b0, {DATA_W{1'b0}}}) begin
      errors++;
      $display("FAIL done c%0d: done=%b rdata=%h err=%b psel=%b pen=%b addr=%h wr=%b wd=%h, want done=%b rdata=%h rest 0",
               c, done_o, rdata_o, err_o, psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
               exp_done, exp_rdata);
    end
    if (!rd) ref_mem[a[3:0]] = d;
    req_i[c] = 1'b0;
    if (noise) req_i[o] = 1'b0;
    @(negedge clk);
    checks++;
    if ({done_o, rdata_o, err_o, psel_o} !== '0) begin
      errors++;
      $display("FAIL pulse_clear c%0d: done=%b rdata=%h err=%b psel=%b, want all 0",
               c, done_o, rdata_o, err_o, psel_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_i = '0; rnw_i = '0; addr_i = '0; wdata_i = '0; pready_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h, want 0", outs);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: outputs=%h, want 0", i, outs);
      end
    end
  endtask

  task automatic test_write_read();
    run_xfer(0, 1'b0, 10'd3, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    run_xfer(1, 1'b1, 10'd3, $urandom, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 14; n++)
      run_xfer(int'($urandom_range(0, 1)), 1'($urandom), ADDR_W'($urandom), $urandom,
               int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0), 1'($urandom));
  endtask

  task automatic test_wait_states();
    run_xfer(0, 1'b0, 10'd5, $urandom, 7, 1'b0, 1'b1);
    run_xfer(1, 1'b1, 10'd5, $urandom, 7, 1'b0, 1'b1);
    req_i[1] = 1'b1; rnw_i[1] = 1'b1; addr_i[ADDR_W +: ADDR_W] = 10'd7; pready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({psel_o, penable_o} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_access: psel=%b pen=%b, want 1 1", psel_o, penable_o);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_mid_access: outputs=%h, want 0", outs);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_held cycle %0d: outputs=%h, want 0", i, outs);
      end
    end
    req_i = '0; reset = 1'b0; pready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({done_o, psel_o} !== 3'b000) begin
        errors++;
        $display("FAIL abandoned_no_done cycle %0d: done=%b psel=%b, want 00 0", i, done_o, psel_o);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [ADDR_W-1:0] cur [2];
    int exp_c, cyc;
    logic [1:0] exp_done;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cur[c] = ADDR_W'($urandom);
      addr_i[c*ADDR_W +: ADDR_W] = cur[c];
    end
    rnw_i = 2'b11; pready_i = 1'b1; req_i = 2'b11; exp_c = 0;
    for (int n = 0; n < 8; n++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (done_o === 2'b00 && cyc < 10);
      exp_done = (exp_c == 0) ? 2'b01 : 2'b10;
      checks++;
      if (done_o !== exp_done || rdata_o !== ref_mem[cur[exp_c][3:0]]) begin
        errors++;
        $display("FAIL rr_grant %0d: done=%b rdata=%h, want done=%b rdata=%h",
                 n, done_o, rdata_o, exp_done, ref_mem[cur[exp_c][3:0]]);
      end
      cur[exp_c] = ADDR_W'($urandom);
      addr_i[exp_c*ADDR_W +: ADDR_W] = cur[exp_c];
      exp_c = 1 - exp_c;
    end
    req_i = '0;
    repeat (2) @(negedge clk);
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, acc;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rnw_i = 2'b11; req_i = 2'b11; pready_i = 1'b0; cyc = 0; acc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (psel_o && penable_o) acc++;
    end while (done_o === 2'b00 && cyc < 40);
    checks++;
    if (done_o !== 2'b01 || err_o !== 1'b1 || rdata_o !== '0 || acc != 15) begin
      errors++;
      $display("FAIL timeout_abort: done=%b err=%b rdata=%h access_cycles=%0d, want 01 1 0 15",
               done_o, err_o, rdata_o, acc);
    end
    req_i[0] = 1'b0; pready_i = 1'b1; cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done_o === 2'b00 && cyc < 10);
    checks++;
    if (done_o !== 2'b10 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_next_grant: done=%b err=%b, want 10 0", done_o, err_o);
    end
    req_i = '0;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_random();
    test_wait_states();
    test_round_robin();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
